// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshakes, carry register,
// saturating add and an iterative shift-add multiply.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       INST,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Z,
    output logic [3:0]       FLAGS
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAXV = ~MINV;

    state_t             state;
    state_t             state_nxt;
    logic               c;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH:0]     step;

    logic               accept;
    logic               is_mul;
    logic               is_arith;
    logic               is_err;
    logic               last;
    logic [WIDTH-1:0]   ax;
    logic [WIDTH-1:0]   ay;
    logic               acin;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   res;
    logic               carry;
    logic               ovf;

    assign IN_READY = !RESET && (state == S_IDLE) && (!OUT_VALID || OUT_READY);
    assign accept   = IN_VALID && IN_READY;
    assign is_mul   = (INST == 5'b10011);
    assign last     = (state == S_MUL) && (cnt == CNT_W'(WIDTH - 1));

    // All arithmetic shares one adder: x + y + cin
    always_comb begin
        ax       = '0;
        ay       = '0;
        acin     = 1'b0;
        is_arith = 1'b0;
        case (INST)
            5'b00000: begin ax = A; acin = 1'b1; is_arith = 1'b1; end
            5'b00001: begin ax = A; ay = ~ONE; acin = 1'b1; is_arith = 1'b1; end
            5'b00010: begin ax = A; ay = B; is_arith = 1'b1; end
            5'b00011: begin ax = A; ay = ~B; acin = 1'b1; is_arith = 1'b1; end
            5'b00100: begin
                if (A[WIDTH-1]) begin
                    ay   = ~A;
                    acin = 1'b1;
                end else begin
                    ax = A;
                end
                is_arith = 1'b1;
            end
            5'b00101: begin ay = ~A; acin = 1'b1; is_arith = 1'b1; end
            5'b00111: begin ay = ~B; acin = 1'b1; is_arith = 1'b1; end
            5'b10000: begin ax = A; ay = B; acin = c; is_arith = 1'b1; end
            5'b10001: begin ax = A; ay = ~B; acin = c; is_arith = 1'b1; end
            5'b10010: begin ax = A; ay = B; is_arith = 1'b1; end
            default: ;
        endcase

        sum   = {1'b0, ax} + {1'b0, ay} + {{WIDTH{1'b0}}, acin};
        carry = is_arith & sum[WIDTH];
        ovf   = is_arith & (ax[WIDTH-1] == ay[WIDTH-1])
                         & (sum[WIDTH-1] != ax[WIDTH-1]);

        res    = sum[WIDTH-1:0];
        is_err = 1'b0;
        case (INST)
            5'b01000: res = A & B;
            5'b01001: res = A | B;
            5'b01010: res = A ^ B;
            5'b01011: res = ~B;
            5'b01100: res = A;
            5'b01101: res = ~A;
            5'b01110: res = '0;
            5'b01111: res = ONES;
            5'b10010: if (ovf) res = A[WIDTH-1] ? MINV : MAXV;
            5'b10011: res = '0;
            default: begin
                if (!is_arith) begin
                    res    = '0;
                    is_err = 1'b1;
                end
            end
        endcase
    end

    // One multiplier bit per cycle; high half accumulates with its carry
    assign step     = {1'b0, prod[2*WIDTH-1:WIDTH]}
                    + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign prod_nxt = {step, prod[WIDTH-1:1]};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && is_mul) state_nxt = S_MUL;
            S_MUL:   if (last) state_nxt = S_DONE;
            S_DONE:  if (!OUT_VALID || OUT_READY) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            OUT_VALID <= 1'b0;
            Z         <= '0;
            FLAGS     <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            mcand     <= '0;
            prod      <= '0;
        end else begin
            if (accept && is_mul) begin
                mcand <= A;
                prod  <= {{WIDTH{1'b0}}, B};
                cnt   <= '0;
            end else if (state == S_MUL) begin
                prod <= prod_nxt;
                cnt  <= cnt + CNT_W'(1);
            end

            if (accept && !is_mul) begin
                Z         <= res;
                FLAGS     <= {is_err, (res == '0), carry, ovf};
                OUT_VALID <= 1'b1;
                if (is_arith) c <= carry;
            end else if (last) begin
                Z         <= prod_nxt[WIDTH-1:0];
                FLAGS     <= {1'b0, (prod_nxt[WIDTH-1:0] == '0),
                              (prod_nxt[2*WIDTH-1:WIDTH] != '0), 1'b0};
                OUT_VALID <= 1'b1;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: 32-bit vector table, multi-cycle
// sequences, and an 8-bit build for the width-dependent cases.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        v32, rdy32, ov32, or32;
    logic [31:0] a32, b32, z32;
    logic [4:0]  inst32;
    logic [3:0]  f32;
    logic        v8, rdy8, ov8, or8;
    logic [7:0]  a8, b8, z8;
    logic [4:0]  inst8;
    logic [3:0]  f8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32), .CNT_W(6)) u32 (
        .CLOCK(clk), .RESET(rst), .IN_VALID(v32), .IN_READY(rdy32),
        .A(a32), .B(b32), .INST(inst32), .OUT_VALID(ov32),
        .OUT_READY(or32), .Z(z32), .FLAGS(f32)
    );

    alu_pipe #(.WIDTH(8), .CNT_W(6)) u8 (
        .CLOCK(clk), .RESET(rst), .IN_VALID(v8), .IN_READY(rdy8),
        .A(a8), .B(b8), .INST(inst8), .OUT_VALID(ov8),
        .OUT_READY(or8), .Z(z8), .FLAGS(f8)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  inst;
        logic [31:0] z;
        logic [3:0]  f;
    } vec_t;

    vec_t tv [28];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Single op on the 32-bit unit; entered and left at posedge+1
    task automatic op32(input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] inst, input logic [31:0] ze,
                        input logic [3:0] fe);
        a32 = a; b32 = b; inst32 = inst; v32 = 1'b1;
        #3 chk("op_rdy", rdy32, 1);
        @(posedge clk); #1;
        v32 = 1'b0;
        chk("op_valid", ov32, 1);
        chk("op_z", z32, ze);
        chk("op_flags", f32, fe);
    endtask

    task automatic mul32(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ze, input logic [3:0] fe);
        int n;
        int busy;
        a32 = a; b32 = b; inst32 = 5'b10011; v32 = 1'b1;
        #3 chk("mul_rdy", rdy32, 1);
        @(posedge clk); #1;
        v32  = 1'b0;
        n    = 0;
        busy = 0;
        while (!ov32 && n < 100) begin
            if (rdy32) busy++;
            @(posedge clk); #1;
            n++;
        end
        chk("mul_latency", n, 32);
        chk("mul_busy_ready", busy, 0);
        chk("mul_z", z32, ze);
        chk("mul_flags", f32, fe);
        chk("mul_done_ready", rdy32, 0);
        @(posedge clk); #1;
        chk("mul_taken", ov32, 0);
        chk("mul_idle_ready", rdy32, 1);
    endtask

    task automatic mul8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ze, input logic [3:0] fe);
        int n;
        a8 = a; b8 = b; inst8 = 5'b10011; v8 = 1'b1;
        #3 chk("mul8_rdy", rdy8, 1);
        @(posedge clk); #1;
        v8 = 1'b0;
        n  = 0;
        while (!ov8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mul8_latency", n, 8);
        chk("mul8_z", z8, ze);
        chk("mul8_flags", f8, fe);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int stale;

        tv[0]  = '{32'hFFFFFFFF, 32'h1, 5'b00010, 32'h0, 4'b0110};
        tv[1]  = '{32'h0, 32'h0, 5'b10000, 32'h1, 4'b0000};
        tv[2]  = '{32'h5, 32'h7, 5'b00011, 32'hFFFFFFFE, 4'b0000};
        tv[3]  = '{32'h7FFFFFFF, 32'h1, 5'b10010, 32'h7FFFFFFF, 4'b0001};
        tv[4]  = '{32'h80000000, 32'hFFFFFFFF, 5'b10010, 32'h80000000, 4'b0011};
        tv[5]  = '{32'hA, 32'h3, 5'b10001, 32'h7, 4'b0010};
        tv[6]  = '{32'h0, 32'h0, 5'b00001, 32'hFFFFFFFF, 4'b0000};
        tv[7]  = '{32'hA, 32'h3, 5'b10001, 32'h6, 4'b0010};
        tv[8]  = '{32'h80000000, 32'h0, 5'b00100, 32'h80000000, 4'b0001};
        tv[9]  = '{32'hFFFFFFFB, 32'h0, 5'b00100, 32'h5, 4'b0000};
        tv[10] = '{32'h7FFFFFFF, 32'h0, 5'b00000, 32'h80000000, 4'b0001};
        tv[11] = '{32'h0, 32'h1, 5'b00111, 32'hFFFFFFFF, 4'b0000};
        tv[12] = '{32'h0, 32'h0, 5'b00101, 32'h0, 4'b0110};
        tv[13] = '{32'hF0F0F0F0, 32'h0FF00FF0, 5'b01000, 32'h00F000F0, 4'b0000};
        tv[14] = '{32'h0F0F0000, 32'h000000F0, 5'b01001, 32'h0F0F00F0, 4'b0000};
        tv[15] = '{32'hFFFF0000, 32'hFF00FF00, 5'b01010, 32'h00FFFF00, 4'b0000};
        tv[16] = '{32'h0, 32'hFFFFFFFF, 5'b01011, 32'h0, 4'b0100};
        tv[17] = '{32'h12345678, 32'h0, 5'b01100, 32'h12345678, 4'b0000};
        tv[18] = '{32'h0, 32'h0, 5'b01101, 32'hFFFFFFFF, 4'b0000};
        tv[19] = '{32'h5, 32'h5, 5'b01110, 32'h0, 4'b0100};
        tv[20] = '{32'h0, 32'h0, 5'b01111, 32'hFFFFFFFF, 4'b0000};
        tv[21] = '{32'h3, 32'h3, 5'b00110, 32'h0, 4'b1100};
        tv[22] = '{32'h1, 32'h1, 5'b10100, 32'h0, 4'b1100};
        tv[23] = '{32'h1, 32'h1, 5'b11111, 32'h0, 4'b1100};
        tv[24] = '{32'h0, 32'h0, 5'b10000, 32'h1, 4'b0000};
        tv[25] = '{32'h0, 32'h0, 5'b10000, 32'h0, 4'b0100};
        tv[26] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 5'b00010, 32'hFFFFFFFE, 4'b0001};
        tv[27] = '{32'hFFFFFFFF, 32'h0, 5'b00000, 32'h0, 4'b0110};

        rst = 1'b1;
        v32 = 1'b0; a32 = '0; b32 = '0; inst32 = '0; or32 = 1'b1;
        v8  = 1'b0; a8  = '0; b8  = '0; inst8  = '0; or8  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", ov32, 0);
        chk("rst_z", z32, 0);
        chk("rst_flags", f32, 0);
        chk("rst_ready", rdy32, 0);
        rst = 1'b0;
        #1 chk("rel_ready", rdy32, 1);
        @(posedge clk); #1;

        // Back-to-back stream: one result per cycle, no bubbles
        for (int i = 0; i < 28; i++) begin
            a32 = tv[i].a; b32 = tv[i].b; inst32 = tv[i].inst; v32 = 1'b1;
            #3 chk($sformatf("vec%0d_rdy", i), rdy32, 1);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", i), ov32, 1);
            chk($sformatf("vec%0d_z", i), z32, tv[i].z);
            chk($sformatf("vec%0d_flags", i), f32, tv[i].f);
        end
        v32 = 1'b0;
        @(posedge clk); #1;

        mul32(32'h10000, 32'h10000, 32'h0, 4'b0110);
        mul32(32'h7, 32'h6, 32'd42, 4'b0000);

        // Backpressure hold then accept on release
        a32 = 32'h2; b32 = 32'h3; inst32 = 5'b00010; v32 = 1'b1;
        @(posedge clk); #1;
        or32 = 1'b0;
        a32 = 32'd10; b32 = 32'd20;
        chk("bp_valid", ov32, 1);
        chk("bp_z0", z32, 5);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold_z%0d", k), z32, 5);
            chk($sformatf("bp_hold_f%0d", k), f32, 0);
            chk($sformatf("bp_hold_v%0d", k), ov32, 1);
            chk($sformatf("bp_hold_rdy%0d", k), rdy32, 0);
        end
        or32 = 1'b1;
        #1 chk("bp_release_rdy", rdy32, 1);
        @(posedge clk); #1;
        v32 = 1'b0;
        chk("bp_next_valid", ov32, 1);
        chk("bp_next_z", z32, 30);
        @(posedge clk); #1;

        // Reset during a multiply: carry cleared, no stale result
        op32(32'hFFFFFFFF, 32'h1, 5'b00010, 32'h0, 4'b0110);
        a32 = 32'h10000; b32 = 32'h10000; inst32 = 5'b10011; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_valid", ov32, 0);
        chk("mrst_ready", rdy32, 0);
        chk("mrst_z", z32, 0);
        rst = 1'b0;
        #1 chk("mrst_rel_ready", rdy32, 1);
        stale = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ov32) stale++;
        end
        chk("mrst_stale", stale, 0);
        op32(32'h0, 32'h0, 5'b10000, 32'h0, 4'b0100);
        @(posedge clk); #1;

        // 8-bit build
        a8 = 8'hFF; b8 = 8'h01; inst8 = 5'b00010; v8 = 1'b1;
        #3 chk("w8_add_rdy", rdy8, 1);
        @(posedge clk); #1;
        chk("w8_add_valid", ov8, 1);
        chk("w8_add_z", z8, 0);
        chk("w8_add_flags", f8, 4'b0110);
        a8 = 8'h00; b8 = 8'h00; inst8 = 5'b10000;
        #3 chk("w8_addc_rdy", rdy8, 1);
        @(posedge clk); #1;
        v8 = 1'b0;
        chk("w8_addc_valid", ov8, 1);
        chk("w8_addc_z", z8, 1);
        chk("w8_addc_flags", f8, 4'b0000);
        @(posedge clk); #1;
        mul8(8'h10, 8'h10, 8'h00, 4'b0110);
        mul8(8'hFF, 8'hFF, 8'h01, 4'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the Functional Unit ALU.
- Adds configurable data width and valid/ready flow control on input and output.
- Restores extended-precision add/subtract through an internal carry register, and adds saturating add and an iterative unsigned multiply (low half).
- Sits between the operand-routing fabric and the writeback/flag logic of the Functional Unit.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CNT_W, 6, width of the multiply iteration counter; must satisfy 2**CNT_W > WIDTH.

Ports:
- CLOCK  input  1  single clock, all state on rising edge
- RESET  input  1  synchronous, active-high reset
- IN_VALID  input  1  operand/instruction presented
- IN_READY  output  1  block accepts operands this cycle
- A  input  WIDTH  first operand (subtract is A-B)
- B  input  WIDTH  second operand
- INST  input  5  opcode
- OUT_VALID  output  1  result/flags valid
- OUT_READY  input  1  consumer takes result this cycle
- Z  output  WIDTH  result
- FLAGS  output  4  {ERR, ZERO, CARRY, OVF}

Behaviour:
- Reset (synchronous, active-high): OUT_VALID=0, Z=0, FLAGS=0, carry register C=0, FSM=IDLE. Any multiply in progress is aborted and no result is produced. IN_READY=0 while RESET=1.
- Accept condition: IN_VALID && IN_READY.
- IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY). This gives full throughput for single-cycle ops.
- Opcodes with INST[4]=0 use the legacy encoding, one cycle:
  - 0000 A+1; 0001 A-1; 0010 A+B; 0011 A-B
  - 0100 |A|; 0101 -A; 0111 -B
  - 1000 A&B; 1001 A|B; 1010 A^B; 1011 ~B
  - 1100 A; 1101 ~A; 1110 0; 1111 all-ones
  - 0110 is reserved.
- Opcodes with INST[4]=1:
  - 10000 ADDC: A+B+C, one cycle.
  - 10001 SUBC: A+~B+C, one cycle. C=1 means no borrow.
  - 10010 SATADD: signed A+B, one cycle. On overflow Z saturates to 0111..1 or 1000..0.
  - 10011 MUL: unsigned A*B, low WIDTH bits, multi-cycle.
  - 101xx and 11xxx are reserved.
- Reserved opcodes: Z=0, FLAGS=1000, C unchanged, one cycle.
- Single-cycle latency: operands accepted in cycle n → OUT_VALID=1 with Z/FLAGS in cycle n+1.
- Output hold: Z/FLAGS stay stable while OUT_VALID && !OUT_READY.
- FSM states:
  - IDLE → MUL on accept of MUL; otherwise stays IDLE.
  - MUL: shift-add, one bit of B per cycle, with counter 0..WIDTH-1. IN_READY=0 throughout.
  - After WIDTH cycles in MUL → DONE. Z loads and OUT_VALID rises on the DONE transition, so the result appears WIDTH+1 cycles after accept.
  - DONE → IDLE when the output is taken (or immediately if the output register is free).
- Flags:
  - ZERO = (Z==0), evaluated for all ops including ERR cases.
  - CARRY, arithmetic ops: adder carry-out. Subtract-class ops (A-B, A-1, -A, -B, SUBC): carry = not-borrow.
  - CARRY, MUL: 1 iff the high WIDTH bits of the full product are nonzero.
  - CARRY, logic/move ops: 0.
  - OVF: signed overflow of the adder result, for arithmetic ops only. SATADD reports the pre-saturation overflow. OVF=0 for logic, move and MUL.
  - ERR: 1 only for reserved opcodes.
- Carry register C: updated with the CARRY flag on every completed arithmetic op. Arithmetic ops are add/sub/inc/dec/abs/neg/ADDC/SUBC/SATADD. C is not updated by logic, move, MUL or reserved ops.
- Edge cases:
  - |A| with A=100..0: Z=100..0, OVF=1.
  - A-1 with A=0: Z=all-ones, CARRY=0.
  - Simultaneous OUT_READY and new accept: the old result is consumed and the new one is loaded in the same edge.
- Arithmetic is modulo 2**WIDTH except SATADD.

Test Plan:
- WIDTH=32, OUT_READY=1, back-to-back ADD 0xFFFFFFFF+1 then ADDC 0+0 → Z=0, FLAGS=0110 (ZERO, CARRY); next Z=1, FLAGS=0000; one result per cycle, no bubbles.
- SUB 5-7 → Z=0xFFFFFFFE, CARRY=0, OVF=0; SATADD 0x7FFFFFFF+1 → Z=0x7FFFFFFF, OVF=1; SATADD 0x80000000+0xFFFFFFFF → Z=0x80000000, OVF=1.
- MUL 0x10000*0x10000 → IN_READY=0 for 32 cycles, Z=0 at cycle 33, FLAGS=0110; MUL 7*6 → Z=42, FLAGS=0000.
- Backpressure: OUT_READY=0 for 5 cycles after an ADD result → Z/FLAGS stable, IN_READY=0, next op accepted the same cycle OUT_READY=1.
- RESET asserted mid-MUL (cycle 10) → next cycle OUT_VALID=0, C=0, IN_READY=1 after release, and no stale result ever appears.
- Reserved INST=5'b00110 with A=B=3 → Z=0, FLAGS=1100, C unchanged (verified by a following ADDC 0+0 = prior C); WIDTH=8 build repeats cases 1 and 3 with 0xFF+1 and 0x10*0x10.
